// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer producing the processor clock-enable at full or slow rate.
// Optional breakpoint halt is compiled in when CPU_BREAKPOINT_EN is defined.
module cpu_run_ctrl #(
    parameter int DIV_SLOW = 2500,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             cpu_halt,
    input  logic             div_sel,
`ifdef CPU_BREAKPOINT_EN
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             bp_hit,
`endif
    output logic             cpu_ce,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] tick_count
);

    localparam int PRE_W = $clog2(DIV_SLOW);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_SLOW - 1);

    typedef enum logic [1:0] {
        S_HALTED,
        S_RUN,
        S_STEP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;
    logic             terminal;
    logic             active;
    logic             bp_fire;
    logic             ce_nxt;
`ifdef CPU_BREAKPOINT_EN
    logic             bp_hit_nxt;
`endif

    always_comb begin
        terminal  = !div_sel || (pre == PRE_LAST);
        active    = (state == S_RUN) || (state == S_STEP);
        bp_fire   = 1'b0;
`ifdef CPU_BREAKPOINT_EN
        bp_fire    = (state == S_RUN) && terminal && bp_en && (pc == bp_addr);
        bp_hit_nxt = bp_hit;
`endif
        // Stop requests and a breakpoint suppress the pulse on the very edge they are seen.
        ce_nxt    = active && terminal && !halt_req && !cpu_halt && !bp_fire;
        state_nxt = state;
        pre_nxt   = (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);

        if (halt_req || cpu_halt) begin
            state_nxt = S_HALTED;
        end else begin
            case (state)
                S_HALTED: begin
                    if (run_req || step_req) begin
                        state_nxt = run_req ? S_RUN : S_STEP;
                        pre_nxt   = '0;
`ifdef CPU_BREAKPOINT_EN
                        bp_hit_nxt = 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (bp_fire) begin
                        state_nxt = S_HALTED;
`ifdef CPU_BREAKPOINT_EN
                        bp_hit_nxt = 1'b1;
`endif
                    end
                end
                S_STEP: begin
                    if (terminal) state_nxt = S_HALTED;
                end
                default: state_nxt = S_HALTED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_HALTED;
            pre        <= '0;
            cpu_ce     <= 1'b0;
            tick_count <= '0;
`ifdef CPU_BREAKPOINT_EN
            bp_hit     <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            pre    <= pre_nxt;
            cpu_ce <= ce_nxt;
            if (ce_nxt) tick_count <= tick_count + CNT_W'(1);
`ifdef CPU_BREAKPOINT_EN
            bp_hit <= bp_hit_nxt;
`endif
        end
    end

    assign running = (state == S_RUN);
    assign halted  = (state == S_HALTED);

endmodule
